// File: rtl/flip_flop_fifo_valid_ready_level.sv
// Flip-flop FIFO with valid/ready on both sides.
// Registered level counter with almost-full/empty flags and sync flush.
module flip_flop_fifo_valid_ready_level #(
  parameter int width = 8,
  parameter int depth = 10,
  parameter int almost_full_level = depth - 2,
  parameter int almost_empty_level = 2,
  localparam int aw = (depth > 1) ? $clog2(depth) : 1,
  localparam int lw = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data,
  output logic [lw-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty
);

  if (depth < 2) begin : g_bad_depth
    $fatal(1, "depth must be >= 2");
  end
  if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_af
    $fatal(1, "almost_full_level out of range");
  end
  if (almost_empty_level < 0 || almost_empty_level > depth - 1) begin : g_bad_ae
    $fatal(1, "almost_empty_level out of range");
  end

  localparam logic [aw-1:0] last = aw'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic             wr_wrap, rd_wrap, wr_wrap_nx, rd_wrap_nx;
  logic             push, pop;

  assign empty      = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
  assign full       = (wr_ptr == rd_ptr) && (wr_wrap != rd_wrap);
  assign up_ready   = ~full;
  assign down_valid = ~empty;
  assign push       = up_valid & up_ready;
  assign pop        = down_valid & down_ready;
  assign down_data  = mem[rd_ptr];

  assign almost_full  = level >= lw'(almost_full_level);
  assign almost_empty = level <= lw'(almost_empty_level);

  // Pointer advance: wrap at depth-1 and toggle the odd-circle bit.
  always_comb begin
    wr_ptr_nx  = wr_ptr + aw'(1);
    wr_wrap_nx = wr_wrap;
    rd_ptr_nx  = rd_ptr + aw'(1);
    rd_wrap_nx = rd_wrap;
    if (wr_ptr == last) begin
      wr_ptr_nx  = '0;
      wr_wrap_nx = ~wr_wrap;
    end
    if (rd_ptr == last) begin
      rd_ptr_nx  = '0;
      rd_wrap_nx = ~rd_wrap;
    end
  end

  // Pointer and level state; flush discards any same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_wrap <= 1'b0;
      rd_ptr  <= '0;
      rd_wrap <= 1'b0;
      level   <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      wr_wrap <= 1'b0;
      rd_ptr  <= '0;
      rd_wrap <= 1'b0;
      level   <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr_nx;
        wr_wrap <= wr_wrap_nx;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr_nx;
        rd_wrap <= rd_wrap_nx;
      end
      unique case ({push, pop})
        2'b10:   level <= level + lw'(1);
        2'b01:   level <= level - lw'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= up_data;
    end
  end

endmodule

// File: tb/tb_flip_flop_fifo_valid_ready_level.sv
// Bench for flip_flop_fifo_valid_ready_level.
// Vector table, directed corners and queue-model random traffic.
module tb_flip_flop_fifo_valid_ready_level;

  localparam int W = 8;
  localparam int D = 10;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [W-1:0]  up_data = '0;
  logic          down_valid;
  logic          down_ready = 1'b0;
  logic [W-1:0]  down_data;
  logic [LW-1:0] level;
  logic          empty, full, almost_full, almost_empty;

  flip_flop_fifo_valid_ready_level #(.width(W), .depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .level(level), .empty(empty),
    .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] q[$];
  int popped = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_model();
    int n;
    n = q.size();
    chk("level", int'(level), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == D));
    chk("up_ready", int'(up_ready), int'(n < D));
    chk("down_valid", int'(down_valid), int'(n > 0));
    chk("almost_full", int'(almost_full), int'(n >= D - 2));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    if (n > 0) chk("down_data", int'(down_data), int'(q[0]));
  endtask

  // Drive one cycle, advance the model and compare #1 after the edge.
  task automatic cycle(input bit uv, input logic [W-1:0] ud,
                       input bit dr, input bit fl);
    bit do_push, do_pop;
    up_valid = uv;
    up_data = ud;
    down_ready = dr;
    flush = fl;
    do_push = uv && (q.size() < D);
    do_pop = dr && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) q.push_back(ud);
    end
    #1;
    chk_model();
    @(negedge clk);
  endtask

  task automatic do_flush();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  typedef struct {
    bit           uv;
    logic [W-1:0] ud;
    bit           dr;
    int           exp_level;
    bit           exp_full;
    logic [W-1:0] exp_data;
    bit           chk_data;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [W-1:0] nxt;
    int cyc;

    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, W'(i + 1), 1'b0, i + 1, (i == 9), 8'h01, 1'b1};
    for (int i = 0; i < 10; i++)
      tbl[10 + i] = '{1'b0, 8'h00, 1'b1, 9 - i, 1'b0, W'(i + 2), (i < 9)};

    #2;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_up_ready", int'(up_ready), 1);
    chk("rst_down_valid", int'(down_valid), 0);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_almost_full", int'(almost_full), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill/drain table.
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].uv, tbl[i].ud, tbl[i].dr, 1'b0);
      chk("tbl_level", int'(level), tbl[i].exp_level);
      chk("tbl_full", int'(full), int'(tbl[i].exp_full));
      if (tbl[i].chk_data)
        chk("tbl_data", int'(down_data), int'(tbl[i].exp_data));
    end
    chk("drain_empty", int'(empty), 1);

    // Simultaneous push/pop at level 1.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("pp1_data", int'(down_data), 8'h55);
    chk("pp1_level", int'(level), 1);
    chk("pp1_empty", int'(empty), 0);
    do_flush();

    // Full with pop: push refused.
    for (int i = 0; i < D; i++) cycle(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
    chk("full_up_ready", int'(up_ready), 0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("fullpop_level", int'(level), 9);
    chk("fullpop_up_ready", int'(up_ready), 1);
    do_flush();

    // Flush at level 6 with push and pop active.
    for (int i = 0; i < 6; i++) cycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b1, 1'b1);
    chk("flush_level", int'(level), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_down_valid", int'(down_valid), 0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("postflush_data", int'(down_data), 8'h3C);
    do_flush();

    // Async reset mid-cycle at level 4.
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_level", int'(level), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_down_valid", int'(down_valid), 0);
    chk("arst_up_ready", int'(up_ready), 1);
    up_valid = 1'b1;
    up_data = 8'h99;
    @(posedge clk);
    #1;
    chk("arst_hold_level", int'(level), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h78, 1'b0, 1'b0);
    chk("arst_first", int'(down_data), 8'h77);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("arst_second", int'(down_data), 8'h78);
    do_flush();

    // Random stream of 25 words, then longer traffic with flushes.
    popped = 0;
    nxt = 8'h01;
    cyc = 0;
    while (popped < 25 && cyc < 600) begin
      bit uv;
      uv = ($urandom_range(0, 3) != 0) && (nxt <= 8'd25);
      cycle(uv, nxt, $urandom_range(0, 2) == 0, 1'b0);
      if (uv && q.size() > 0 && q[q.size() - 1] == nxt) nxt++;
      cyc++;
    end
    chk("stream_done", popped, 25);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) == 1, W'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
